// File: rtl/dly_lane_loader_if.sv
// ---------------------------------------------------------------------------
// dly_lane_loader_if
// Command handshake between a delay-training controller and the
// dly_lane_loader sequencer.
//
// Signals:
//   cmd_valid  controller has a command on the bus
//   cmd_ready  loader accepts the command on this edge
//   cmd_lane   target lane index
//   cmd_all    broadcast to every lane (cmd_lane ignored)
//   cmd_dir    0 = IDELAY, 1 = ODELAY
//   cmd_data   delay value to load
//   cmd_last   commit (issue the ld strobe) after this command
//
// Modports: master = controller side, slave = loader side.
// ---------------------------------------------------------------------------
interface dly_lane_loader_if #(
   parameter int LANE_BITS = 4,
   parameter int DLY_WIDTH = 8
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [LANE_BITS-1:0] cmd_lane;
   logic                 cmd_all;
   logic                 cmd_dir;
   logic [DLY_WIDTH-1:0] cmd_data;
   logic                 cmd_last;

   modport master (
      output cmd_valid, cmd_lane, cmd_all, cmd_dir, cmd_data, cmd_last,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_lane, cmd_all, cmd_dir, cmd_data, cmd_last,
      output cmd_ready
   );
endinterface

// File: rtl/dly_lane_loader.sv
// ---------------------------------------------------------------------------
// dly_lane_loader
// Delay-programming sequencer for one DDR3 PHY byte group. Each accepted
// command drives the shared dly_data bus and pulses one-hot (or broadcast)
// per-lane set strobes; a command flagged last then waits LD_GAP ready
// cycles and fires the global ld strobes for whichever directions were
// touched since the previous commit.
//
// Ports:
//   clk, rst          clk_div domain clock, synchronous active-high reset
//   dly_ready         IDELAYCTRL rdy (asynchronous, synchronised inside)
//   cmd               command handshake (slave side)
//   dly_data          shared delay value to all lanes
//   set_idelay/odelay per-lane load strobes, one cycle
//   ld_idelay/odelay  global apply strobes, one cycle
//   busy              sequencer is not idle
//   done              one-cycle pulse when a commit completes
//   err               sticky out-of-range lane flag, cleared by err_clr
// ---------------------------------------------------------------------------
module dly_lane_loader #(
   parameter int NUM_LANES = 10,
   parameter int LANE_BITS = 4,
   parameter int DLY_WIDTH = 8,
   parameter int LD_GAP    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 dly_ready,
   dly_lane_loader_if.slave     cmd,
   output logic [DLY_WIDTH-1:0] dly_data,
   output logic [NUM_LANES-1:0] set_idelay,
   output logic [NUM_LANES-1:0] set_odelay,
   output logic                 ld_idelay,
   output logic                 ld_odelay,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   input  logic                 err_clr
);

   typedef enum logic [2:0] {IDLE, SET, GAP, LD, DONE} state_t;

   state_t               state_q;
   logic [1:0]           rdySync_q;
   logic [DLY_WIDTH-1:0] dlyData_q;
   logic [NUM_LANES-1:0] setIdelay_q;
   logic [NUM_LANES-1:0] setOdelay_q;
   logic [NUM_LANES-1:0] pendI_q;
   logic [NUM_LANES-1:0] pendO_q;
   logic                 ldIdelay_q;
   logic                 ldOdelay_q;
   logic                 done_q;
   logic                 err_q;
   logic                 last_q;
   logic [3:0]           gapCnt_q;

   logic                 rdyS;
   logic                 cmdReady;
   logic                 accept_d;
   logic [NUM_LANES-1:0] laneMask_d;
   logic                 laneBad_d;
   logic [3:0]           gapCnt_d;

   assign rdyS     = rdySync_q[1];
   assign cmdReady = (state_q == IDLE) & rdyS;
   assign accept_d = cmd.cmd_valid & cmdReady;
   assign gapCnt_d = gapCnt_q - 4'd1;

   // Strobe mask for the incoming command. An out-of-range lane produces an
   // empty mask so nothing is loaded, and raises the sticky error instead.
   always_comb begin
      laneMask_d = '0;
      laneBad_d  = 1'b0;
      if (cmd.cmd_all) begin
         laneMask_d = '1;
      end else if ({1'b0, cmd.cmd_lane} < (LANE_BITS+1)'(NUM_LANES)) begin
         laneMask_d = NUM_LANES'(1) << cmd.cmd_lane;
      end else begin
         laneBad_d = 1'b1;
      end
   end

   // Sequencer. All outputs are registered here; the strobes default low
   // every cycle so each one is a single-cycle pulse from the state that
   // sets it. The GAP counter only advances while the synchronised ready is
   // high, so a dropout stretches the gap by exactly its length.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rdySync_q   <= '0;
         dlyData_q   <= '0;
         setIdelay_q <= '0;
         setOdelay_q <= '0;
         pendI_q     <= '0;
         pendO_q     <= '0;
         ldIdelay_q  <= 1'b0;
         ldOdelay_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         last_q      <= 1'b0;
         gapCnt_q    <= '0;
      end else begin
         rdySync_q   <= {rdySync_q[0], dly_ready};
         setIdelay_q <= '0;
         setOdelay_q <= '0;
         ldIdelay_q  <= 1'b0;
         ldOdelay_q  <= 1'b0;
         done_q      <= 1'b0;

         if (accept_d && laneBad_d) begin
            err_q <= 1'b1;
         end else if (err_clr) begin
            err_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  dlyData_q <= cmd.cmd_data;
                  last_q    <= cmd.cmd_last;
                  if (cmd.cmd_dir) begin
                     setOdelay_q <= laneMask_d;
                     pendO_q     <= pendO_q | laneMask_d;
                  end else begin
                     setIdelay_q <= laneMask_d;
                     pendI_q     <= pendI_q | laneMask_d;
                  end
                  state_q <= SET;
               end
            end
            SET: begin
               if (last_q) begin
                  gapCnt_q <= 4'(LD_GAP);
                  state_q  <= GAP;
               end else begin
                  state_q <= IDLE;
               end
            end
            GAP: begin
               if (rdyS) begin
                  gapCnt_q <= gapCnt_d;
                  if (gapCnt_d == 4'd0) begin
                     ldIdelay_q <= |pendI_q;
                     ldOdelay_q <= |pendO_q;
                     state_q    <= LD;
                  end
               end
            end
            LD: begin
               pendI_q <= '0;
               pendO_q <= '0;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cmd.cmd_ready = cmdReady;
   assign dly_data      = dlyData_q;
   assign set_idelay    = setIdelay_q;
   assign set_odelay    = setOdelay_q;
   assign ld_idelay     = ldIdelay_q;
   assign ld_odelay     = ldOdelay_q;
   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign err           = err_q;

endmodule

// File: tb/tb_dly_lane_loader.sv
// ---------------------------------------------------------------------------
// tb_dly_lane_loader
// Randomised bench for dly_lane_loader. Reset pulses and dly_ready dropouts
// are scheduled up front; commands are random every cycle. A transaction
// model predicts, per cycle, the strobes, ld pulses, done, busy, ready,
// dly_data and err from the timing rules (accept -> strobe next cycle,
// ld one cycle after the LD_GAP-th ready cycle following the strobe).
// ---------------------------------------------------------------------------
module tb_dly_lane_loader;

   localparam int NUM_LANES = 10;
   localparam int LANE_BITS = 4;
   localparam int DLY_WIDTH = 8;
   localparam int LD_GAP    = 2;
   localparam int NCYC      = 3000;
   localparam int ASZ       = NCYC + 64;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 dlyReady;
   logic                 errClr;
   logic [DLY_WIDTH-1:0] dlyData;
   logic [NUM_LANES-1:0] setIdelay;
   logic [NUM_LANES-1:0] setOdelay;
   logic                 ldIdelay;
   logic                 ldOdelay;
   logic                 busy;
   logic                 done;
   logic                 err;

   dly_lane_loader_if #(.LANE_BITS(LANE_BITS), .DLY_WIDTH(DLY_WIDTH)) cmdIf ();

   dly_lane_loader #(
      .NUM_LANES(NUM_LANES),
      .LANE_BITS(LANE_BITS),
      .DLY_WIDTH(DLY_WIDTH),
      .LD_GAP   (LD_GAP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .dly_ready (dlyReady),
      .cmd       (cmdIf),
      .dly_data  (dlyData),
      .set_idelay(setIdelay),
      .set_odelay(setOdelay),
      .ld_idelay (ldIdelay),
      .ld_odelay (ldOdelay),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_clr   (errClr)
   );

   // Free-running clk_div clock
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int curCycle    = 0;

   // Schedules and expected pulse trains, indexed by cycle
   bit                   rstSched [ASZ];
   bit                   rdyIn    [ASZ];
   bit                   rdyEff   [ASZ];
   logic [NUM_LANES-1:0] expSetI  [ASZ];
   logic [NUM_LANES-1:0] expSetO  [ASZ];
   bit                   expLdI   [ASZ];
   bit                   expLdO   [ASZ];
   bit                   expDone  [ASZ];

   // Model state describing the current cycle
   int                   freeAt;
   logic                 errModel;
   logic [DLY_WIDTH-1:0] dataModel;
   logic [NUM_LANES-1:0] pendI;
   logic [NUM_LANES-1:0] pendO;

   // Synchronised ready as seen by the sequencer in cycle c: dly_ready from
   // two cycles earlier, with the samples swallowed by a reset zeroed.
   function automatic bit rdyS(input int c);
      return (c >= 2) ? rdyEff[c-2] : 1'b0;
   endfunction

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h",
                  tag, curCycle, observed, expected);
      end
   endtask

   // Compare every DUT output against the model for cycle k
   task automatic checkCycle(input int k);
      bit expBusy;
      expBusy = (k < freeAt);
      checkOutput("cmd_ready",  32'(cmdIf.cmd_ready), 32'(!expBusy && rdyS(k)));
      checkOutput("busy",       32'(busy),            32'(expBusy));
      checkOutput("set_idelay", 32'(setIdelay),       32'(expSetI[k]));
      checkOutput("set_odelay", 32'(setOdelay),       32'(expSetO[k]));
      checkOutput("dly_data",   32'(dlyData),         32'(dataModel));
      checkOutput("ld_idelay",  32'(ldIdelay),        32'(expLdI[k]));
      checkOutput("ld_odelay",  32'(ldOdelay),        32'(expLdO[k]));
      checkOutput("done",       32'(done),            32'(expDone[k]));
      checkOutput("err",        32'(err),             32'(errModel));
   endtask

   // Drive random inputs for cycle k and advance the model to cycle k+1
   task automatic applyStimulus(input int k);
      bit                   valid, all, dir, last, clr, readyNow, setErr, found;
      logic [LANE_BITS-1:0] lane;
      logic [DLY_WIDTH-1:0] data;
      logic [NUM_LANES-1:0] mask;
      int                   cnt, c, ldAt;

      valid = ($urandom_range(0, 9) < 7);
      all   = ($urandom_range(0, 9) == 0);
      lane  = ($urandom_range(0, 6) == 0) ? LANE_BITS'($urandom_range(10, 15))
                                          : LANE_BITS'($urandom_range(0, 9));
      dir   = 1'($urandom_range(0, 1));
      data  = DLY_WIDTH'($urandom);
      last  = ($urandom_range(0, 9) < 3);
      clr   = ($urandom_range(0, 9) == 0);

      rst             = rstSched[k];
      dlyReady        = rdyIn[k];
      errClr          = clr;
      cmdIf.cmd_valid = valid;
      cmdIf.cmd_lane  = lane;
      cmdIf.cmd_all   = all;
      cmdIf.cmd_dir   = dir;
      cmdIf.cmd_data  = data;
      cmdIf.cmd_last  = last;

      readyNow = (k >= freeAt) && rdyS(k);

      if (rstSched[k]) begin
         for (int j = k + 1; j < ASZ; j++) begin
            expSetI[j] = '0;
            expSetO[j] = '0;
            expLdI[j]  = 1'b0;
            expLdO[j]  = 1'b0;
            expDone[j] = 1'b0;
         end
         freeAt    = k + 1;
         errModel  = 1'b0;
         dataModel = '0;
         pendI     = '0;
         pendO     = '0;
      end else begin
         setErr = 1'b0;
         if (valid && readyNow) begin
            if (all) begin
               mask = '1;
            end else if (int'(lane) < NUM_LANES) begin
               mask = NUM_LANES'(1) << lane;
            end else begin
               mask   = '0;
               setErr = 1'b1;
            end
            if (dir) begin
               expSetO[k+1] = mask;
               pendO        = pendO | mask;
            end else begin
               expSetI[k+1] = mask;
               pendI        = pendI | mask;
            end
            dataModel = data;
            if (last) begin
               cnt   = 0;
               c     = k + 2;
               found = 1'b0;
               while (c < ASZ - 2 && !found) begin
                  if (rdyS(c)) cnt++;
                  if (cnt == LD_GAP) found = 1'b1;
                  else c++;
               end
               if (found) begin
                  ldAt = c + 1;
                  if (ldAt + 1 < ASZ) begin
                     expLdI[ldAt]    = |pendI;
                     expLdO[ldAt]    = |pendO;
                     expDone[ldAt+1] = 1'b1;
                  end
                  freeAt = ldAt + 2;
               end else begin
                  freeAt = ASZ + 10;
               end
               pendI = '0;
               pendO = '0;
            end else begin
               freeAt = k + 2;
            end
         end
         if (setErr) errModel = 1'b1;
         else if (clr) errModel = 1'b0;
      end
   endtask

   initial begin
      int lowLeft;
      lowLeft = 0;
      for (int i = 0; i < ASZ; i++) begin
         rstSched[i] = (i < 3) ? 1'b1 : ($urandom_range(0, 399) == 0);
         if (lowLeft == 0 && i > 5 && $urandom_range(0, 39) == 0)
            lowLeft = $urandom_range(1, 8);
         rdyIn[i] = (lowLeft == 0);
         if (lowLeft > 0) lowLeft--;
         expSetI[i] = '0;
         expSetO[i] = '0;
         expLdI[i]  = 1'b0;
         expLdO[i]  = 1'b0;
         expDone[i] = 1'b0;
      end
      for (int i = 0; i < ASZ; i++) rdyEff[i] = rdyIn[i];
      for (int i = 0; i < ASZ; i++) begin
         if (rstSched[i]) begin
            rdyEff[i] = 1'b0;
            if (i > 0) rdyEff[i-1] = 1'b0;
         end
      end

      freeAt    = 0;
      errModel  = 1'b0;
      dataModel = '0;
      pendI     = '0;
      pendO     = '0;

      curCycle = 0;
      applyStimulus(0);
      for (int k = 1; k < NCYC; k++) begin
         @(posedge clk);
         #1;
         curCycle = k;
         checkCycle(k);
         applyStimulus(k);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
